// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel synchroniser, 4-state filter FSM and stability counter.
// Define DEBOUNCE_EDGE_EN to build the registered rise/fall strobes; otherwise they are tied to 0.
module debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 2_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d  [CHANNELS];
  state_t                 state_q [CHANNELS];
  state_t                 state_d [CHANNELS];
  logic [CW-1:0]          cnt_q   [CHANNELS];
  logic [CW-1:0]          cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]    deb_q;
  logic [CHANNELS-1:0]    deb_d;

  // Bit 0 of each chain is the first stage; the top bit feeds the FSM.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], noisy[i]};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE_LOW: begin
          if (sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = WAIT_HIGH;
            cnt_d[i]   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = STABLE_LOW;
          end else if (cnt_q[i] == LAST_CNT) begin
            state_d[i] = STABLE_HIGH;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = WAIT_LOW;
            cnt_d[i]   = '0;
          end
        end
        WAIT_LOW: begin
          if (sync_q[i][SYNC_STAGES-1]) begin
            state_d[i] = STABLE_HIGH;
          end else if (cnt_q[i] == LAST_CNT) begin
            state_d[i] = STABLE_LOW;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = STABLE_LOW;
          cnt_d[i]   = '0;
        end
      endcase
      deb_d[i] = (state_d[i] == STABLE_HIGH) || (state_d[i] == WAIT_LOW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= STABLE_LOW;
        cnt_q[i]   <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q <= deb_d;
    end
  end

  assign debounced = deb_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] fall_d;

  // Strobes compare the next level with the current one so they line up with the level change.
  always_comb begin
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi: directed scenarios plus randomized inputs
// checked against a run-length reference model.
module tb_debouncer_multi;

  localparam int CH = 4;
  localparam int S  = 8;
  localparam int SY = 2;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  debouncer_multi #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(S),
    .SYNC_STAGES  (SY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .noisy    (noisy),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: samples of noisy since reset, and the run of consecutive
  // FSM-visible samples that disagree with the current level.
  logic [CH-1:0] samp[$];
  logic [CH-1:0] m_deb;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  int            run[CH];

  task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("debounced", debounced, m_deb);
    chk("rise", rise, EDGE ? m_rise : '0);
    chk("fall", fall, EDGE ? m_fall : '0);
  endtask

  task automatic model_clear();
    samp.delete();
    m_deb  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) run[c] = 0;
  endtask

  // One clock edge: update the model, then check outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) begin
      logic s;
      s = (samp.size() >= SY) ? samp[samp.size() - SY][c] : 1'b0;
      if (s != m_deb[c]) begin
        run[c]++;
        if (run[c] == S + 1) begin
          m_deb[c] = s;
          if (s) m_rise[c] = 1'b1;
          else   m_fall[c] = 1'b1;
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
    samp.push_back(noisy);
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges, checks the immediate clear, holds over one edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_async_deb", debounced, '0);
    chk("rst_async_rise", rise, '0);
    chk("rst_async_fall", fall, '0);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  int lat;
  int nrise;
  int nfall;

  initial begin
    reset = 1'b1;
    noisy = '0;
    model_clear();
    #12;
    check_outputs();
    reset = 1'b0;

    // Channel 0 rising latency, other channels quiet
    do_reset();
    repeat (3) tick();
    noisy[0] = 1'b1;
    lat = -1;
    nrise = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (debounced[0] && lat < 0) lat = n;
      nrise += int'(rise[0]);
    end
    chk_int("ch0_latency", lat, SY + S);
    chk_int("ch0_rise_count", nrise, EDGE ? 1 : 0);
    chk("ch1to3_quiet", debounced & 4'b1110, '0);

    // Channel 1 glitches of 5 and 7 cycles are filtered out
    do_reset();
    noisy = '0;
    nrise = 0;
    nfall = 0;
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      noisy[1] = (n < 5) || (n >= 8 && n < 15);
      tick();
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
      lat += int'(debounced[1]);
    end
    chk_int("ch1_glitch_deb", lat, 0);
    chk_int("ch1_glitch_strobes", nrise + nfall, 0);

    // Channel 2 falling latency from a settled high level
    noisy[2] = 1'b1;
    repeat (14) tick();
    chk("ch2_high", debounced & 4'b0100, 4'b0100);
    noisy[2] = 1'b0;
    lat = -1;
    nfall = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (!debounced[2] && lat < 0) lat = n;
      nfall += int'(fall[2]);
    end
    chk_int("ch2_fall_latency", lat, SY + S);
    chk_int("ch2_fall_count", nfall, EDGE ? 1 : 0);

    // All channels rise on the same edge
    do_reset();
    noisy = '1;
    lat = -1;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (debounced != '0 && lat < 0) begin
        lat = n;
        chk("all_deb_together", debounced, '1);
        chk("all_rise_together", rise, EDGE ? 4'b1111 : 4'b0000);
      end
    end
    chk_int("all_latency", lat, SY + S);

    // Reset mid-WAIT_HIGH on channel 3, input still high through release
    do_reset();
    noisy = 4'b1000;
    repeat (SY + 4) tick();
    do_reset();
    lat = -1;
    nrise = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (debounced[3] && lat < 0) lat = n;
      nrise += int'(rise[3]);
    end
    chk_int("ch3_post_reset_latency", lat, SY + S);
    chk_int("ch3_post_reset_rise", nrise, EDGE ? 1 : 0);

    // Randomized bursts: each channel toggles with varying probability per phase
    do_reset();
    noisy = '0;
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned odds;
      odds = (ph % 3 == 0) ? 3 : ((ph % 3 == 1) ? 8 : 20);
      for (int n = 0; n < 300; n++) begin
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(odds - 1, 0) == 0) noisy[c] = ~noisy[c];
        end
        tick();
      end
      if (ph == 3) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
